// File: rtl/pico_ctrl_if.sv
// Bus between the picoMips fetch/decode sequencer and its ROM/ALU/register-file side.
// The controller takes the master modport; the datapath side takes the slave modport.
interface pico_ctrl_if #(
  parameter int PCW = 8
);
  logic [15:0]    Instr;
  logic [7:0]     ACC;
  logic           Button;
  logic [PCW-1:0] PC;
  logic [7:0]     Imm;
  logic           SelImm;
  logic           SelSW;
  logic           SelRegData;
  logic           UseMul;
  logic           UseACC;
  logic           WE;
  logic [3:0]     RegAddr;
  logic           RegWE;
  logic           Halted;

  modport master (
    input  Instr, ACC, Button,
    output PC, Imm, SelImm, SelSW, SelRegData, UseMul, UseACC, WE,
           RegAddr, RegWE, Halted
  );

  modport slave (
    output Instr, ACC, Button,
    input  PC, Imm, SelImm, SelSW, SelRegData, UseMul, UseACC, WE,
           RegAddr, RegWE, Halted
  );
endinterface

// File: rtl/pico_ctrl.sv
// picoMips fetch/decode sequencer: two cycles per instruction (FETCH, EXEC), plus
// branch, jump, button wait and halt. Define PICO_CTRL_BTN_SYNC_EN to synchronise Button.
module pico_ctrl #(
  parameter int PCW = 8
) (
  input  logic         Clock,
  input  logic         nReset,
  pico_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_EXEC    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LDSW  = 4'h2;
  localparam logic [3:0] OP_ADDI  = 4'h3;
  localparam logic [3:0] OP_ADDR  = 4'h4;
  localparam logic [3:0] OP_MULI  = 4'h5;
  localparam logic [3:0] OP_STR   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_BZ    = 4'h8;
  localparam logic [3:0] OP_WAITP = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

  state_t         r_state;
  state_t         w_state_next;
  logic [PCW-1:0] r_pc;
  logic [PCW-1:0] w_pc_next;
  logic [PCW-1:0] w_pc_inc;
  logic [PCW-1:0] w_target;
  logic [3:0]     w_op;
  logic           w_btn;
  logic           w_acc_zero;

  logic w_sel_imm;
  logic w_sel_sw;
  logic w_sel_reg;
  logic w_use_mul;
  logic w_use_acc;
  logic w_we;
  logic w_reg_we;

`ifdef PICO_CTRL_BTN_SYNC_EN
  logic [1:0] r_btn_sync;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_btn_sync <= 2'b00;
    end else begin
      r_btn_sync <= {r_btn_sync[0], bus.Button};
    end
  end

  assign w_btn = r_btn_sync[1];
`else
  assign w_btn = bus.Button;
`endif

  assign w_op       = bus.Instr[15:12];
  assign w_pc_inc   = r_pc + PC_ONE;
  assign w_acc_zero = (bus.ACC == 8'd0);

  // Jump targets come from the 8-bit immediate; narrower PCs truncate, wider ones zero-extend.
  generate
    if (PCW <= 8) begin : g_target_trunc
      assign w_target = bus.Instr[PCW-1:0];
    end else begin : g_target_ext
      assign w_target = {{(PCW-8){1'b0}}, bus.Instr[7:0]};
    end
  endgenerate

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_sel_imm    = 1'b0;
    w_sel_sw     = 1'b0;
    w_sel_reg    = 1'b0;
    w_use_mul    = 1'b0;
    w_use_acc    = 1'b0;
    w_we         = 1'b0;
    w_reg_we     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_state_next = S_EXEC;
      end

      S_EXEC: begin
        w_state_next = S_FETCH;
        w_pc_next    = w_pc_inc;
        case (w_op)
          OP_LDI: begin
            w_sel_imm = 1'b1;
            w_we      = 1'b1;
          end
          OP_LDSW: begin
            w_sel_sw = 1'b1;
            w_we     = 1'b1;
          end
          OP_ADDI: begin
            w_use_acc = 1'b1;
            w_sel_imm = 1'b1;
            w_we      = 1'b1;
          end
          OP_ADDR: begin
            w_use_acc = 1'b1;
            w_sel_reg = 1'b1;
            w_we      = 1'b1;
          end
          OP_MULI: begin
            w_use_acc = 1'b1;
            w_use_mul = 1'b1;
            w_we      = 1'b1;
          end
          OP_STR: begin
            w_reg_we = 1'b1;
          end
          OP_JMP: begin
            w_pc_next = w_target;
          end
          OP_BZ: begin
            if (w_acc_zero) begin
              w_pc_next = w_target;
            end
          end
          OP_WAITP: begin
            w_pc_next    = r_pc;
            w_state_next = S_WAIT_HI;
          end
          OP_HALT: begin
            w_pc_next    = r_pc;
            w_state_next = S_HALT;
          end
          default: begin
          end
        endcase
      end

      S_WAIT_HI: begin
        if (w_btn) begin
          w_state_next = S_WAIT_LO;
        end
      end

      // The PC only advances on release, so one press retires exactly one WAITP.
      S_WAIT_LO: begin
        if (!w_btn) begin
          w_state_next = S_FETCH;
          w_pc_next    = w_pc_inc;
        end
      end

      S_HALT: begin
      end

      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  assign bus.PC         = r_pc;
  assign bus.Imm        = bus.Instr[7:0];
  assign bus.RegAddr    = bus.Instr[11:8];
  assign bus.SelImm     = w_sel_imm;
  assign bus.SelSW      = w_sel_sw;
  assign bus.SelRegData = w_sel_reg;
  assign bus.UseMul     = w_use_mul;
  assign bus.UseACC     = w_use_acc;
  assign bus.WE         = w_we;
  assign bus.RegWE      = w_reg_we;
  assign bus.Halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_pico_ctrl.sv
// Randomised scoreboard bench for pico_ctrl: an instruction-level model pushes the expected
// outputs of every clock cycle, and a monitor pops and compares them mid-cycle.
module tb_pico_ctrl;

  localparam int PCW = 8;
`ifdef PICO_CTRL_BTN_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  typedef struct {
    logic [7:0] pc;
    logic [6:0] en;
    logic       halted;
    logic       chk_imm;
    logic [7:0] imm;
    logic [3:0] ra;
  } exp_t;

  logic Clock;
  logic nReset;
  pico_ctrl_if #(.PCW(PCW)) bus ();

  pico_ctrl #(.PCW(PCW)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  logic [15:0] rom [0:255];
  exp_t        sb [$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [7:0] m_pc;
  logic       h1, h2;
  int         acc_force = -1;
  bit         rand_btn  = 1'b0;
  bit         rand_wait = 1'b0;
  int         wl = 0, wh = 1, wabort = -1;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous program ROM: word for the current PC appears after the next edge.
  always @(posedge Clock) bus.Instr <= rom[bus.PC];

  function automatic logic [6:0] en_of(input logic [3:0] op);
    // {SelImm, SelSW, SelRegData, UseMul, UseACC, WE, RegWE}
    case (op)
      4'h1:    return 7'b1000010;
      4'h2:    return 7'b0100010;
      4'h3:    return 7'b1000110;
      4'h4:    return 7'b0010110;
      4'h5:    return 7'b0001110;
      4'h6:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t mk(input logic [7:0] pc, input logic [6:0] en, input logic hl,
                              input logic chk, input logic [7:0] imm, input logic [3:0] ra);
    exp_t e;
    e.pc = pc; e.en = en; e.halted = hl; e.chk_imm = chk; e.imm = imm; e.ra = ra;
    return e;
  endfunction

  function automatic logic rbtn();
    return rand_btn ? 1'($urandom_range(1, 0)) : 1'b0;
  endfunction

  // One clock cycle: drive inputs, record expectation, report the button the FSM sees.
  task automatic step(input logic rst_n, input logic btn, input logic [7:0] acc,
                      input exp_t e, output logic eff);
    @(posedge Clock);
    #1;
    nReset     = rst_n;
    bus.Button = btn;
    bus.ACC    = acc;
    eff = SYNC ? h2 : btn;
    if (!rst_n) begin
      h1 = 1'b0;
      h2 = 1'b0;
    end else begin
      h2 = h1;
      h1 = btn;
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    logic eff;
    repeat (3) step(1'b0, 1'b0, 8'd0, mk(8'd0, 7'd0, 1'b0, 1'b0, 8'd0, 4'd0), eff);
    m_pc = 8'd0;
  endtask

  // Button wait: effective button must go high, then low; release advances PC.
  task automatic do_wait();
    int   k;
    bit   lo_phase;
    bit   done;
    logic eff;
    logic b;
    k = 0; lo_phase = 1'b0; done = 1'b0;
    if (rand_wait) begin
      wl = $urandom_range(4, 0);
      wh = $urandom_range(3, 1);
    end
    while (!done) begin
      if (k == wabort) begin
        do_reset();
        done = 1'b1;
      end else begin
        b = (k >= wl) && (k < wl + wh);
        step(1'b1, b, 8'($urandom), mk(m_pc, 7'd0, 1'b0, 1'b0, 8'd0, 4'd0), eff);
        k++;
        if (!lo_phase) begin
          if (eff) lo_phase = 1'b1;
        end else if (!eff) begin
          m_pc = m_pc + 8'd1;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic run_instr(output bit halted);
    logic [15:0] w;
    logic [3:0]  op;
    logic [7:0]  acc;
    logic        eff;
    halted = 1'b0;
    step(1'b1, rbtn(), 8'($urandom), mk(m_pc, 7'd0, 1'b0, 1'b0, 8'd0, 4'd0), eff);
    w  = rom[m_pc];
    op = w[15:12];
    if (acc_force >= 0) acc = acc_force[7:0];
    else acc = ($urandom_range(1, 0) == 1) ? 8'd0 : 8'($urandom_range(255, 1));
    step(1'b1, rbtn(), acc, mk(m_pc, en_of(op), 1'b0, 1'b1, w[7:0], w[11:8]), eff);
    $display("exec pc=%02h instr=%04h acc=%02h", m_pc, w, acc);
    case (op)
      4'h7:    m_pc = w[7:0];
      4'h8:    m_pc = (acc == 8'd0) ? w[7:0] : m_pc + 8'd1;
      4'h9:    do_wait();
      4'hF:    halted = 1'b1;
      default: m_pc = m_pc + 8'd1;
    endcase
  endtask

  task automatic run_halt();
    logic eff;
    repeat (20) step(1'b1, rbtn(), 8'($urandom), mk(m_pc, 7'd0, 1'b1, 1'b0, 8'd0, 4'd0), eff);
  endtask

  task automatic run_prog(input int max_instr);
    bit h;
    do_reset();
    for (int i = 0; i < max_instr; i++) begin
      run_instr(h);
      if (h) begin
        run_halt();
        break;
      end
    end
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
  endtask

  // Monitor: compares the DUT against the oldest expectation in the middle of each cycle.
  initial begin
    forever begin
      @(negedge Clock);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_checks++;
        if (bus.PC !== mon_e.pc) begin
          n_fail++;
          $display("FAIL pc: got %02h expected %02h at %0t", bus.PC, mon_e.pc, $time);
        end
        n_checks++;
        if ({bus.SelImm, bus.SelSW, bus.SelRegData, bus.UseMul, bus.UseACC, bus.WE,
             bus.RegWE} !== mon_e.en) begin
          n_fail++;
          $display("FAIL enables: got %07b expected %07b pc=%02h at %0t",
                   {bus.SelImm, bus.SelSW, bus.SelRegData, bus.UseMul, bus.UseACC,
                    bus.WE, bus.RegWE}, mon_e.en, mon_e.pc, $time);
        end
        n_checks++;
        if (bus.Halted !== mon_e.halted) begin
          n_fail++;
          $display("FAIL halted: got %b expected %b at %0t", bus.Halted, mon_e.halted, $time);
        end
        if (mon_e.chk_imm) begin
          n_checks++;
          if (bus.Imm !== mon_e.imm || bus.RegAddr !== mon_e.ra) begin
            n_fail++;
            $display("FAIL imm_regaddr: got %02h/%01h expected %02h/%01h at %0t",
                     bus.Imm, bus.RegAddr, mon_e.imm, mon_e.ra, $time);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit h;
    nReset     = 1'b0;
    bus.Button = 1'b0;
    bus.ACC    = 8'd0;
    h1 = 1'b0;
    h2 = 1'b0;
    m_pc = 8'd0;
    clear_rom();

    // Straight-line ALU program ending in HALT
    rom[0] = 16'h1005; rom[1] = 16'h3003; rom[2] = 16'h6200; rom[3] = 16'hF000;
    run_prog(10);

    // Branch taken, branch not taken, jump to top of memory, wrap to 0
    clear_rom();
    rom[8'h00] = 16'h8010; rom[8'h10] = 16'h8020; rom[8'h11] = 16'h70FF; rom[8'hFF] = 16'h0000;
    do_reset();
    acc_force = 0; run_instr(h);
    acc_force = 1; run_instr(h);
    acc_force = -1; run_instr(h); run_instr(h);
    run_instr(h);

    // Button wait: low 5 cycles, high 3, then release; then halt
    clear_rom();
    rom[0] = 16'h9000; rom[1] = 16'hF000;
    wl = 5; wh = 3; wabort = -1;
    run_prog(4);

    // Reset in the middle of the wait, then a complete wait and halt
    wl = 10; wh = 2; wabort = 3;
    do_reset();
    run_instr(h);
    wabort = -1;
    run_instr(h);
    run_instr(h);
    if (h) run_halt();

    // Unassigned opcode behaves as NOP
    clear_rom();
    rom[0] = 16'hC3FF; rom[1] = 16'hA123; rom[2] = 16'hF000;
    run_prog(5);

    // Random programs with random buttons, accumulators and waits
    rand_btn = 1'b1; rand_wait = 1'b1;
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 256; a++) rom[a] = 16'($urandom);
      run_prog(60);
    end

    @(posedge Clock);
    @(posedge Clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
